// File: rtl/clk_gate_ctrl.sv
// Clock-gating enable controller: gates after a programmable idle run,
// re-enables on activity and flags ready once the gated domain settles.
module clk_gate_ctrl #(
  parameter int CW          = 8,
  parameter int WAKE_CYCLES = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          busy,
  input  logic          wake,
  input  logic          force_on,
  input  logic [CW-1:0] idle_cycles,
  output logic          clk_en,
  output logic          ready,
  output logic          gated
);

  typedef enum logic [1:0] {
    ST_WAKE  = 2'd0,
    ST_ON    = 2'd1,
    ST_GATED = 2'd2
  } state_t;

  localparam logic [7:0] LP_WAKE_LAST = 8'(WAKE_CYCLES - 1);

  state_t        r_state;
  logic [CW-1:0] r_idle_cnt;
  logic [7:0]    r_wake_cnt;

  logic          w_act;
  logic [CW:0]   w_idle_inc;
  logic          w_thr_hit;

  assign w_act      = busy | wake | force_on;
  assign w_idle_inc = {1'b0, r_idle_cnt} + {{CW{1'b0}}, 1'b1};
  assign w_thr_hit  = (idle_cycles != '0) &&
                      (w_idle_inc >= {1'b0, idle_cycles});

  // Outputs are set together with the state they belong to, so they
  // only ever move right after a posedge or on reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= ST_WAKE;
      r_idle_cnt <= '0;
      r_wake_cnt <= '0;
      clk_en     <= 1'b1;
      ready      <= 1'b0;
      gated      <= 1'b0;
    end else begin
      unique case (r_state)
        ST_ON: begin
          if (w_act) begin
            r_idle_cnt <= '0;
          end else if (w_thr_hit) begin
            r_state    <= ST_GATED;
            r_idle_cnt <= '0;
            clk_en     <= 1'b0;
            ready      <= 1'b0;
            gated      <= 1'b1;
          end else if (r_idle_cnt != '1) begin
            r_idle_cnt <= r_idle_cnt + 1'b1;
          end
        end
        ST_GATED: begin
          r_idle_cnt <= '0;
          if (w_act) begin
            r_state    <= ST_WAKE;
            r_wake_cnt <= '0;
            clk_en     <= 1'b1;
            ready      <= 1'b0;
            gated      <= 1'b0;
          end
        end
        ST_WAKE: begin
          r_idle_cnt <= '0;
          if (r_wake_cnt == LP_WAKE_LAST) begin
            r_state    <= ST_ON;
            r_wake_cnt <= '0;
            clk_en     <= 1'b1;
            ready      <= 1'b1;
            gated      <= 1'b0;
          end else begin
            r_wake_cnt <= r_wake_cnt + 1'b1;
          end
        end
        default: begin
          r_state    <= ST_WAKE;
          r_idle_cnt <= '0;
          r_wake_cnt <= '0;
          clk_en     <= 1'b1;
          ready      <= 1'b0;
          gated      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_clk_gate_ctrl.sv
// Directed bench for clk_gate_ctrl: reset, idle gating, threshold race,
// wake latency, disable/override, threshold change and async reset.
module tb_clk_gate_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       busy;
  logic       wake;
  logic       force_on;
  logic [7:0] idle_cycles;
  logic       clk_en;
  logic       ready;
  logic       gated;

  int checks = 0;
  int errors = 0;
  bit inv_on = 1'b0;

  clk_gate_ctrl #(.CW(8), .WAKE_CYCLES(2)) dut (
    .clk         (clk),
    .reset       (reset),
    .busy        (busy),
    .wake        (wake),
    .force_on    (force_on),
    .idle_cycles (idle_cycles),
    .clk_en      (clk_en),
    .ready       (ready),
    .gated       (gated)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic outs(input string tag, input logic e, input logic r,
                      input logic g);
    chk({tag, "_en"}, 32'(clk_en), 32'(e));
    chk({tag, "_rdy"}, 32'(ready), 32'(r));
    chk({tag, "_gat"}, 32'(gated), 32'(g));
  endtask

  // Structural invariants sampled mid-cycle.
  always @(negedge clk) begin
    if (inv_on) begin
      chk("inv_gated", 32'(gated), 32'(!clk_en));
      chk("inv_ready", 32'(ready && !clk_en), 32'(0));
    end
  end

  task automatic wake_to_on();
    wake = 1'b1;
    tick();
    wake = 1'b0;
    tick();
    tick();
  endtask

  initial begin
    bit ok;
    reset = 1'b1; busy = 1'b0; wake = 1'b0; force_on = 1'b0;
    idle_cycles = 8'd4;
    repeat (3) tick();
    outs("rst", 1'b1, 1'b0, 1'b0);
    chk("rst_cnt", 32'(dut.r_idle_cnt), 32'd0);
    inv_on = 1'b1;
    reset = 1'b0;

    tick();
    outs("exit1", 1'b1, 1'b0, 1'b0);
    tick();
    outs("exit2", 1'b1, 1'b1, 1'b0);
    repeat (3) tick();
    outs("idle3", 1'b1, 1'b1, 1'b0);
    tick();
    outs("idle4", 1'b0, 1'b0, 1'b1);

    wake = 1'b1;
    tick();
    outs("wk0", 1'b1, 1'b0, 1'b0);
    wake = 1'b0;
    tick();
    outs("wk1", 1'b1, 1'b0, 1'b0);
    tick();
    outs("wk2", 1'b1, 1'b1, 1'b0);

    repeat (3) tick();
    chk("race_cnt3", 32'(dut.r_idle_cnt), 32'd3);
    busy = 1'b1;
    tick();
    busy = 1'b0;
    outs("race", 1'b1, 1'b1, 1'b0);
    chk("race_cnt0", 32'(dut.r_idle_cnt), 32'd0);
    repeat (3) tick();
    chk("race_on3", 32'(clk_en), 32'd1);
    tick();
    outs("race_gate", 1'b0, 1'b0, 1'b1);

    wake_to_on();
    idle_cycles = 8'd0;
    ok = 1'b1;
    for (int i = 0; i < 300; i++) begin
      tick();
      if (!clk_en) ok = 1'b0;
    end
    chk("dis_never", 32'(ok), 32'd1);
    chk("dis_sat", 32'(dut.r_idle_cnt), 32'd255);

    force_on = 1'b1;
    idle_cycles = 8'd1;
    ok = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (!clk_en) ok = 1'b0;
    end
    chk("force_never", 32'(ok), 32'd1);
    force_on = 1'b0;
    tick();
    outs("force_rel", 1'b0, 1'b0, 1'b1);

    wake_to_on();
    idle_cycles = 8'd10;
    repeat (6) tick();
    outs("thr6", 1'b1, 1'b1, 1'b0);
    idle_cycles = 8'd3;
    tick();
    outs("thr_low", 1'b0, 1'b0, 1'b1);

    wake = 1'b1;
    tick();
    wake = 1'b0;
    tick();
    outs("mid_wk", 1'b1, 1'b0, 1'b0);
    chk("mid_wcnt", 32'(dut.r_wake_cnt), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    outs("arst", 1'b1, 1'b0, 1'b0);
    chk("arst_wcnt", 32'(dut.r_wake_cnt), 32'd0);
    #1;
    reset = 1'b0;
    tick();
    outs("re1", 1'b1, 1'b0, 1'b0);
    tick();
    outs("re2", 1'b1, 1'b1, 1'b0);

    idle_cycles = 8'd2;
    repeat (2) tick();
    chk("g_pre", 32'(gated), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    outs("arst_g", 1'b1, 1'b0, 1'b0);
    reset = 1'b0;
    tick();
    tick();
    chk("arst_g_rdy", 32'(ready), 32'd1);

    inv_on = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/clk_gate_ctrl.md
Name: clk_gate_ctrl

Overview:
- Sequential controller that produces the registered enable consumed by the team's clk-low-transparent latch in the clock-gating cell.
- Tracks activity of the gated domain and drops the enable after a programmable run of idle cycles.
- Re-enables the clock on demand and reports when the gated domain is clocked and settled.
- Sits beside each gating cell at the boundary between the free-running clock and a gated sub-block.

Parameters:
- CW, 8, width of the idle threshold and idle counter.
- WAKE_CYCLES, 2, posedges from enable re-assertion to ready; legal range 1..255.

Ports:
- clk  in  1  free-running clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- busy  in  1  gated domain has work in flight.
- wake  in  1  external request to run the gated domain.
- force_on  in  1  override: never gate while high.
- idle_cycles  in  CW  idle threshold; 0 disables gating.
- clk_en  out  1  enable to the gating latch; flop output, changes only just after posedge, so it is stable while clk is low.
- ready  out  1  gated domain clocked and settled.
- gated  out  1  high while the clock is gated off.

Behaviour:
- Reset values (async, immediate on reset=1):
  - state=WAKE, clk_en=1, ready=0, gated=0, idle counter=0, wake counter=0.
  - Reset mid-operation in any state returns to these values.
- activity = busy | wake | force_on, sampled each posedge.
- All outputs are registered and are pure functions of state:
  - ON: clk_en=1, ready=1, gated=0.
  - WAKE: clk_en=1, ready=0, gated=0.
  - GATED: clk_en=0, ready=0, gated=1.
- ON:
  - Idle counter increments (saturating at 2^CW-1) on each posedge with activity=0.
  - Idle counter clears on each posedge with activity=1.
  - Go to GATED at the posedge where activity=0 and (counter+1) >= idle_cycles, with idle_cycles != 0.
  - So clk_en falls after exactly idle_cycles consecutive idle samples.
  - Activity on the threshold cycle wins: stay in ON, clear the counter.
  - idle_cycles==0: never leave ON; the counter still runs and saturates.
  - idle_cycles lowered below the current count: gate on the next idle sample.
- GATED:
  - Idle counter holds 0.
  - On the posedge sampling activity=1, go to WAKE; clk_en=1 after that edge.
  - No minimum gated time.
- WAKE:
  - Wake counter increments each posedge regardless of inputs; activity is ignored and gating is not allowed.
  - At the posedge where wake counter reaches WAKE_CYCLES-1, go to ON, clear both counters; ready=1 after that edge.
  - Net latency: activity sampled at edge N gives clk_en=1 after edge N and ready=1 after edge N+WAKE_CYCLES.
- Exit from reset: ready rises after the WAKE_CYCLES-th posedge following reset deassertion.
- Invariants:
  - ready=1 implies clk_en=1.
  - gated == !clk_en at all times.
  - clk_en never changes other than immediately after a posedge or on reset assertion.
- No combinational path from any input to any output.

Test Plan:
- Reset then idle: reset=1 for 3 cycles, release, WAKE_CYCLES=2, all inputs 0, idle_cycles=4 -> ready=1 after 2nd posedge; clk_en=0 and gated=1 after 4 further idle posedges.
- Threshold race: idle_cycles=4, busy pulses high exactly on the 4th idle sample -> remains ON, counter=0; gating occurs only after 4 more idle samples.
- Wake from gated: in GATED, wake=1 for one cycle at edge N -> clk_en=1 after N, ready=0 until after N+2, then ready=1; wake dropping during WAKE does not regate.
- Disable and override: idle_cycles=0 for 300 idle cycles -> never gates, counter saturates at 255; force_on=1 with idle_cycles=1 -> never gates.
- Threshold change: idle_cycles=10, idle for 6 cycles, then set idle_cycles=3 -> gates on the next idle posedge.
- Reset mid-WAKE: assert reset asynchronously between edges in WAKE -> outputs go to reset values immediately; full wake sequence restarts after release.
